// File: rtl/piso_shift_reg_if.sv
// Load/serial-out bundle for piso_shift_reg: the producer/consumer side drives the
// master modport, the shift register itself sits on the slave modport.
interface piso_shift_reg_if #(
  parameter int WIDTH = 32
);

  logic [WIDTH-1:0] d;
  logic             load_valid;
  logic             load_ready;
  logic             shift_en;
  logic             sout;
  logic             sout_valid;
  logic             last;
  logic             busy;

  modport master (
    output d,
    output load_valid,
    output shift_en,
    input  load_ready,
    input  sout,
    input  sout_valid,
    input  last,
    input  busy
  );

  modport slave (
    input  d,
    input  load_valid,
    input  shift_en,
    output load_ready,
    output sout,
    output sout_valid,
    output last,
    output busy
  );

endinterface

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register: accepts one WIDTH-bit word via valid/ready
// and emits it one bit per shift_en, MSB or LSB first, with bubble-free reload.
module piso_shift_reg #(
  parameter int WIDTH     = 32,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  piso_shift_reg_if.slave bus
);

  localparam int              CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]   LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] sreg;
  logic [WIDTH-1:0] sreg_nxt;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             at_last;

  assign at_last = (state == SHIFT) && (count == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sreg  <= '0;
      count <= '0;
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      count <= count_nxt;
    end
  end

  // On the final bit a waiting word is taken in the same edge so words stream back to back.
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    count_nxt = count;
    case (state)
      IDLE: begin
        if (bus.load_valid) begin
          sreg_nxt  = bus.d;
          count_nxt = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.shift_en) begin
          if (count == LAST_IDX) begin
            count_nxt = '0;
            if (bus.load_valid) begin
              sreg_nxt = bus.d;
            end else begin
              state_nxt = IDLE;
            end
          end else begin
            sreg_nxt  = MSB_FIRST ? (sreg << 1) : (sreg >> 1);
            count_nxt = count + CW'(1);
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Every output is forced low while rst is held, regardless of the registered state.
  always_comb begin
    bus.load_ready = 1'b0;
    bus.sout       = 1'b0;
    bus.sout_valid = 1'b0;
    bus.last       = 1'b0;
    bus.busy       = 1'b0;
    if (!rst) begin
      if (state == IDLE) begin
        bus.load_ready = 1'b1;
      end else begin
        bus.busy       = 1'b1;
        bus.sout_valid = 1'b1;
        bus.sout       = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
        bus.last       = at_last;
        bus.load_ready = at_last && bus.shift_en;
      end
    end
  end

  a_stall_holds: assert property (@(posedge clk) disable iff (rst)
    (state == SHIFT && !bus.shift_en) |=> ($stable(sreg) && $stable(count)));

  a_load_starts: assert property (@(posedge clk) disable iff (rst)
    (state == IDLE && bus.load_valid) |=> (state == SHIFT && count == '0));

  a_advance_counts: assert property (@(posedge clk) disable iff (rst)
    (state == SHIFT && bus.shift_en && !at_last) |=> (count == $past(count) + CW'(1)));

endmodule

// File: tb/tb_piso_shift_reg.sv
// Self-checking bench for piso_shift_reg: an MSB-first and an LSB-first instance,
// directed vectors, and a bit-list model compared every cycle.
module tb_piso_shift_reg;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  piso_shift_reg_if #(.WIDTH(W)) bus0 ();
  piso_shift_reg_if #(.WIDTH(W)) bus1 ();

  piso_shift_reg #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(bus0));
  piso_shift_reg #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(bus1));

  always #5 clk = ~clk;

  // Model: the word as an ordered list of bits still owed to the consumer.
  bit exp_bits [2][W];
  int exp_len  [2];
  int exp_head [2];

  bit got0 [$];
  bit got1 [$];
  int valid_cnt [2];
  int busy_cnt [2];
  int ready_busy_cnt [2];
  int last_cnt [2];
  int last_idx [2];

  function automatic int remaining(input int k);
    return exp_len[k] - exp_head[k];
  endfunction

  function automatic bit model_ready(input int k, input logic se);
    return (remaining(k) == 0) || (remaining(k) == 1 && se);
  endfunction

  task automatic model_step(input int k, input logic lv, input logic se, input logic [W-1:0] dv);
    bit acc;
    if (rst) begin
      exp_len[k]  = 0;
      exp_head[k] = 0;
      return;
    end
    acc = lv && model_ready(k, se);
    if (remaining(k) > 0 && se) exp_head[k]++;
    if (acc) begin
      for (int i = 0; i < W; i++) exp_bits[k][i] = (k == 0) ? dv[W-1-i] : dv[i];
      exp_len[k]  = W;
      exp_head[k] = 0;
    end
  endtask

  always @(posedge clk) begin
    model_step(0, bus0.load_valid, bus0.shift_en, bus0.d);
    model_step(1, bus1.load_valid, bus1.shift_en, bus1.d);
  end

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic compare_inst(input int k, input logic lr, input logic so, input logic sv,
                              input logic la, input logic bz, input logic se);
    string pfx;
    bit    e_valid;
    bit    e_sout;
    pfx     = (k == 0) ? "msb" : "lsb";
    e_valid = !rst && remaining(k) > 0;
    e_sout  = e_valid ? exp_bits[k][exp_head[k]] : 1'b0;
    checkOutput({pfx, ".load_ready"}, W'(lr), W'(!rst && model_ready(k, se)));
    checkOutput({pfx, ".sout_valid"}, W'(sv), W'(e_valid));
    checkOutput({pfx, ".busy"},       W'(bz), W'(e_valid));
    checkOutput({pfx, ".last"},       W'(la), W'(e_valid && remaining(k) == 1));
    checkOutput({pfx, ".sout"},       W'(so), W'(e_sout));
  endtask

  always @(negedge clk) begin
    compare_inst(0, bus0.load_ready, bus0.sout, bus0.sout_valid, bus0.last, bus0.busy, bus0.shift_en);
    compare_inst(1, bus1.load_ready, bus1.sout, bus1.sout_valid, bus1.last, bus1.busy, bus1.shift_en);
  end

  always @(negedge clk) begin
    if (bus0.sout_valid) valid_cnt[0]++;
    if (bus0.busy) busy_cnt[0]++;
    if (bus0.busy && bus0.load_ready) ready_busy_cnt[0]++;
    if (bus0.last) begin
      last_cnt[0]++;
      last_idx[0] = got0.size();
    end
    if (bus0.sout_valid && bus0.shift_en) got0.push_back(bus0.sout);
    if (bus1.sout_valid) valid_cnt[1]++;
    if (bus1.busy) busy_cnt[1]++;
    if (bus1.busy && bus1.load_ready) ready_busy_cnt[1]++;
    if (bus1.last) begin
      last_cnt[1]++;
      last_idx[1] = got1.size();
    end
    if (bus1.sout_valid && bus1.shift_en) got1.push_back(bus1.sout);
  end

  function automatic logic [W-1:0] pack_word(input int k, input int start);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      bit b;
      b = (k == 0) ? got0[start+i] : got1[start+i];
      if (k == 0) w[W-1-i] = b;
      else        w[i]     = b;
    end
    return w;
  endfunction

  task automatic clear_obs(input int k);
    valid_cnt[k]      = 0;
    busy_cnt[k]       = 0;
    ready_busy_cnt[k] = 0;
    last_cnt[k]       = 0;
    last_idx[k]       = -1;
    if (k == 0) got0.delete();
    else        got1.delete();
  endtask

  task automatic applyStimulus(input int k, input logic r, input logic lv,
                               input logic [W-1:0] dv, input logic se);
    rst = r;
    if (k == 0) begin
      bus0.load_valid = lv;
      bus0.d          = dv;
      bus0.shift_en   = se;
    end else begin
      bus1.load_valid = lv;
      bus1.d          = dv;
      bus1.shift_en   = se;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst             = 1'b1;
    bus0.load_valid = 1'b1;
    bus0.d          = '1;
    bus0.shift_en   = 1'b1;
    bus1.load_valid = 1'b1;
    bus1.d          = '1;
    bus1.shift_en   = 1'b1;
    clear_obs(0);
    clear_obs(1);

    // Reset held with load and shift requests active
    applyStimulus(0, 1'b1, 1'b1, '1, 1'b1);
    applyStimulus(0, 1'b1, 1'b1, '1, 1'b1);
    rst             = 1'b0;
    bus0.load_valid = 1'b0;
    bus0.shift_en   = 1'b0;
    bus1.load_valid = 1'b0;
    bus1.shift_en   = 1'b0;
    #1;
    checkOutput("reset.msb_ready_after", W'(bus0.load_ready), 32'd1);
    checkOutput("reset.lsb_ready_after", W'(bus1.load_ready), 32'd1);
    checkOutput("reset.msb_busy_after", W'(bus0.busy), 32'd0);

    // MSB-first word
    clear_obs(0);
    applyStimulus(0, 1'b0, 1'b1, 32'hA500_0001, 1'b0);
    for (int i = 0; i < W; i++) applyStimulus(0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("msb.busy_dropped", W'(bus0.busy), 32'd0);
    checkOutput("msb.bit_count", got0.size(), 32'd32);
    checkOutput("msb.word", pack_word(0, 0), 32'hA500_0001);
    checkOutput("msb.last_count", last_cnt[0], 32'd1);
    checkOutput("msb.last_index", last_idx[0], 32'd31);

    // LSB-first word
    clear_obs(1);
    applyStimulus(1, 1'b0, 1'b1, 32'h0000_0006, 1'b0);
    for (int i = 0; i < W; i++) applyStimulus(1, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("lsb.busy_dropped", W'(bus1.busy), 32'd0);
    checkOutput("lsb.bit_count", got1.size(), 32'd32);
    checkOutput("lsb.valid_cycles", valid_cnt[1], 32'd32);
    checkOutput("lsb.word", pack_word(1, 0), 32'h0000_0006);

    // Stalls with ignored mid-word load pulses
    clear_obs(0);
    applyStimulus(0, 1'b0, 1'b1, 32'hFFFF_0000, 1'b0);
    for (int i = 0; i < 200; i++) begin
      applyStimulus(0, 1'b0, (i % 3) == 1, 32'h0000_0000, (i % 3) == 0);
      if (!bus0.busy) break;
    end
    checkOutput("stall.finished", W'(bus0.busy), 32'd0);
    checkOutput("stall.bit_count", got0.size(), 32'd32);
    checkOutput("stall.word", pack_word(0, 0), 32'hFFFF_0000);

    // Back-to-back words 0, 6, 12
    clear_obs(0);
    for (int c = 0; c <= 96; c++) begin
      logic [W-1:0] dv;
      dv = (c == 0) ? 32'd0 : 32'(6 * ((c - 1) / 32 + 1));
      applyStimulus(0, 1'b0, c <= 64, dv, 1'b1);
    end
    checkOutput("b2b.busy_dropped", W'(bus0.busy), 32'd0);
    checkOutput("b2b.valid_cycles", valid_cnt[0], 32'd96);
    checkOutput("b2b.busy_cycles", busy_cnt[0], 32'd96);
    checkOutput("b2b.ready_pulses", ready_busy_cnt[0], 32'd3);
    checkOutput("b2b.last_count", last_cnt[0], 32'd3);
    checkOutput("b2b.bit_count", got0.size(), 32'd96);
    checkOutput("b2b.word0", pack_word(0, 0), 32'd0);
    checkOutput("b2b.word1", pack_word(0, 32), 32'd6);
    checkOutput("b2b.word2", pack_word(0, 64), 32'd12);

    // Reset mid-word, then a fresh word
    clear_obs(0);
    applyStimulus(0, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("midrst.partial_bits", got0.size(), 32'd10);
    applyStimulus(0, 1'b1, 1'b0, '0, 1'b1);
    rst           = 1'b0;
    bus0.shift_en = 1'b0;
    #1;
    checkOutput("midrst.busy", W'(bus0.busy), 32'd0);
    checkOutput("midrst.sout_valid", W'(bus0.sout_valid), 32'd0);
    clear_obs(0);
    applyStimulus(0, 1'b0, 1'b1, 32'h0000_000F, 1'b0);
    for (int i = 0; i < W; i++) applyStimulus(0, 1'b0, 1'b0, '0, 1'b1);
    checkOutput("midrst.busy_dropped", W'(bus0.busy), 32'd0);
    checkOutput("midrst.bit_count", got0.size(), 32'd32);
    checkOutput("midrst.word", pack_word(0, 0), 32'h0000_000F);
    checkOutput("midrst.last_index", last_idx[0], 32'd31);

    applyStimulus(0, 1'b0, 1'b0, '0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
